// File: rtl/weight_pkg.sv
// Shared definitions for the weight encoder family: FSM state encoding and
// helpers that convert between a one-hot weight and the range of patterns
// carrying that many ones. Helpers work on the maximum supported width
// (MAX_W); callers zero-extend or truncate to their own width.
package weight_pkg;

   localparam int MAX_W = 8;
   localparam int EXT_W = MAX_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      ERR  = 2'd2
   } state_e;

   // True when exactly one bit of the weight vector is set.
   function automatic logic onehot_valid(input logic [EXT_W-1:0] vec);
      return (vec != '0) && ((vec & (vec - EXT_W'(1))) == '0);
   endfunction

   // Position of the set bit of a one-hot vector (0 for an all-zero vector).
   function automatic logic [3:0] onehot_index(input logic [EXT_W-1:0] vec);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < EXT_W; i++) begin
         if (vec[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Smallest value with k ones: the k low bits set.
   function automatic logic [MAX_W-1:0] first_of_weight(input logic [3:0] k);
      logic [EXT_W-1:0] mask;
      // Computed one bit wider so that k == MAX_W yields all ones.
      mask = (EXT_W'(1) << k) - EXT_W'(1);
      return MAX_W'(mask);
   endfunction

   // Largest width-bit value with k ones: the k high bits of the width set.
   function automatic logic [MAX_W-1:0] last_of_weight(input logic [3:0] k,
                                                       input logic [3:0] width);
      return first_of_weight(k) << (width - k);
   endfunction

endpackage

// File: rtl/next_same_weight.sv
// Combinational successor of a bit pattern within its popcount class.
//   value_i : current WIDTH-bit pattern
//   next_o  : next larger WIDTH-bit value with the same number of ones;
//             returns value_i unchanged when no larger value exists
//             (0, all ones, or the largest value of its weight), so the
//             result never wraps past 2^WIDTH-1.
// Method: find the lowest "01" boundary (bit i set, bit i+1 clear), move
// that one up to i+1, and pack the ones that were below i into the bottom.
module next_same_weight #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] value_i,
   output logic [WIDTH-1:0] next_o
);

   logic found;
   int   pos;
   int   ones;

   // NOTE: every variable assigned in this always_comb gets a default first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      next_o = value_i;
      found  = 1'b0;
      pos    = 0;
      ones   = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (!found) begin
            if (value_i[i] && !value_i[i+1]) begin
               found = 1'b1;
               pos   = i;
            end else if (value_i[i]) begin
               ones = ones + 1;
            end
         end
      end
      if (found) begin
         next_o[pos+1] = 1'b1;
         for (int j = 0; j < WIDTH; j++) begin
            if (j <= pos) next_o[j] = (j < ones);
         end
      end
   end

endmodule

// File: rtl/weight_pattern_gen.sv
// Enumerates every WIDTH-bit pattern with a requested popcount, ascending,
// one pattern per pat_valid/pat_ready handshake.
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid     : request present
//   req_ready     : idle, request may be accepted
//   req_weight    : one-hot weight (bit k = k ones), sampled at acceptance
//   pat_valid     : pat_data/pat_last/pat_index hold a pattern
//   pat_ready     : consumer takes the current pattern
//   pat_data      : current pattern
//   pat_last      : current pattern is the final one of the request
//   pat_index     : zero-based ordinal of the pattern within the request
//   err           : one-cycle pulse after a request that was not one-hot
// All outputs come straight from flops.
module weight_pattern_gen
   import weight_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH:0]   req_weight,
   output logic             pat_valid,
   input  logic             pat_ready,
   output logic [WIDTH-1:0] pat_data,
   output logic             pat_last,
   output logic [WIDTH-1:0] pat_index,
   output logic             err
);

   state_e           state_q,     state_d;
   logic [3:0]       weight_q,    weight_d;
   logic [WIDTH-1:0] pat_data_q,  pat_data_d;
   logic [WIDTH-1:0] pat_index_q, pat_index_d;
   logic             req_ready_q, req_ready_d;
   logic             pat_valid_q, pat_valid_d;
   logic             pat_last_q,  pat_last_d;
   logic             err_q,       err_d;

   logic [EXT_W-1:0] req_ext;
   logic [WIDTH-1:0] next_pat;

   assign req_ext = EXT_W'(req_weight);

   next_same_weight #(.WIDTH(WIDTH)) u_next (
      .value_i (pat_data_q),
      .next_o  (next_pat)
   );

   always_comb begin
      state_d     = state_q;
      weight_d    = weight_q;
      pat_data_d  = pat_data_q;
      pat_index_d = pat_index_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               if (onehot_valid(req_ext)) begin
                  weight_d    = onehot_index(req_ext);
                  pat_data_d  = WIDTH'(first_of_weight(onehot_index(req_ext)));
                  pat_index_d = '0;
                  state_d     = EMIT;
               end else begin
                  state_d = ERR;
               end
            end
         end
         EMIT: begin
            if (pat_ready) begin
               if (pat_last_q) begin
                  state_d = IDLE;
               end else begin
                  pat_data_d  = next_pat;
                  pat_index_d = pat_index_q + WIDTH'(1);
               end
            end
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered: derive them from the next state so they
      // line up with the state they describe.
      req_ready_d = (state_d == IDLE);
      pat_valid_d = (state_d == EMIT);
      err_d       = (state_d == ERR);
      pat_last_d  = (state_d == EMIT) &&
                    (MAX_W'(pat_data_d) == last_of_weight(weight_d, 4'(WIDTH)));
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         weight_q    <= '0;
         pat_data_q  <= '0;
         pat_index_q <= '0;
         req_ready_q <= 1'b0;
         pat_valid_q <= 1'b0;
         pat_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         weight_q    <= weight_d;
         pat_data_q  <= pat_data_d;
         pat_index_q <= pat_index_d;
         req_ready_q <= req_ready_d;
         pat_valid_q <= pat_valid_d;
         pat_last_q  <= pat_last_d;
         err_q       <= err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign pat_valid = pat_valid_q;
   assign pat_data  = pat_data_q;
   assign pat_last  = pat_last_q;
   assign pat_index = pat_index_q;
   assign err       = err_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Self-checking bench for weight_pattern_gen (WIDTH=4). Expected patterns
// are generated by enumerating all values and filtering by popcount, pushed
// to a queue at request time and popped on each handshake.
module tb_weight_pattern_gen;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH:0]   req_weight;
   logic             pat_valid;
   logic             pat_ready;
   logic [WIDTH-1:0] pat_data;
   logic             pat_last;
   logic [WIDTH-1:0] pat_index;
   logic             err;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] index;
      logic             last;
   } exp_t;

   exp_t           exp_q[$];
   int             errors = 0;
   int             checks = 0;
   logic [WIDTH:0] cur_weight;

   weight_pattern_gen #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_weight (req_weight),
      .pat_valid  (pat_valid),
      .pat_ready  (pat_ready),
      .pat_data   (pat_data),
      .pat_last   (pat_last),
      .pat_index  (pat_index),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic int weight_of(input logic [WIDTH:0] w);
      if ($countones(w) != 1) return -1;
      for (int i = 0; i <= WIDTH; i++) if (w[i]) return i;
      return -1;
   endfunction

   task automatic push_expected(input logic [WIDTH:0] w);
      int k;
      int idx;
      k   = weight_of(w);
      idx = 0;
      if (k < 0) return;
      for (int v = 0; v < (1 << WIDTH); v++) begin
         logic [WIDTH-1:0] vv;
         exp_t e;
         vv = WIDTH'(v);
         if ($countones(vv) == k) begin
            e.data  = vv;
            e.index = WIDTH'(idx);
            e.last  = 1'b0;
            exp_q.push_back(e);
            idx++;
         end
      end
      exp_q[exp_q.size()-1].last = 1'b1;
   endtask

   task automatic check_idle_outputs_zero(input string tag);
      checks++;
      if ({req_ready, pat_valid, pat_data, pat_last, pat_index, err} !== '0) begin
         errors++;
         $display("FAIL %s: outputs rdy=%b vld=%b data=%0d last=%b idx=%0d err=%b, want all 0",
                  tag, req_ready, pat_valid, pat_data, pat_last, pat_index, err);
      end
   endtask

   // Called at a negedge; returns at the negedge of the cycle after acceptance.
   task automatic request(input logic [WIDTH:0] w);
      int t;
      t = 0;
      while (req_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: req_ready=%b, want 1", req_ready);
      end
      cur_weight = w;
      req_valid  = 1'b1;
      req_weight = w;
      push_expected(w);
      @(negedge clk);
      req_valid  = 1'b0;
      req_weight = (WIDTH+1)'($urandom_range(0, 31));
   endtask

   // Consumes up to max_n patterns; bp selects ready pattern 1,0,0,1 repeating.
   task automatic drain(input bit bp, input int max_n, output int n);
      int               cyc;
      int               phase;
      bit               stalled;
      logic [WIDTH-1:0] hd, hi;
      logic             hl;
      exp_t             e;
      cyc = 0; phase = 0; stalled = 1'b0; n = 0;
      hd = '0; hi = '0; hl = 1'b0;
      while (exp_q.size() > 0 && n < max_n && cyc < 200) begin
         checks++;
         if (pat_valid !== 1'b1) begin
            errors++;
            $display("FAIL pat_valid: got %b, want 1", pat_valid);
         end
         if (stalled) begin
            checks++;
            if ({pat_data, pat_index, pat_last} !== {hd, hi, hl}) begin
               errors++;
               $display("FAIL stall_hold: got data=%0d idx=%0d last=%b, want data=%0d idx=%0d last=%b",
                        pat_data, pat_index, pat_last, hd, hi, hl);
            end
         end
         pat_ready = bp ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b1;
         phase++;
         if (pat_ready) begin
            e = exp_q.pop_front();
            checks++;
            if (pat_data !== e.data) begin
               errors++;
               $display("FAIL pat_data: got %0d, want %0d", pat_data, e.data);
            end
            checks++;
            if (pat_index !== e.index) begin
               errors++;
               $display("FAIL pat_index: got %0d, want %0d", pat_index, e.index);
            end
            checks++;
            if (pat_last !== e.last) begin
               errors++;
               $display("FAIL pat_last: got %b, want %b (data %0d)", pat_last, e.last, e.data);
            end
            checks++;
            if (((WIDTH+1)'(1) << $countones(pat_data)) !== cur_weight) begin
               errors++;
               $display("FAIL encode: pattern %0d encodes to %b, want %b", pat_data,
                        (WIDTH+1)'(1) << $countones(pat_data), cur_weight);
            end
            n++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            hd = pat_data; hi = pat_index; hl = pat_last;
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d patterns left, want 0", exp_q.size());
      end else if (exp_q.size() == 0) begin
         checks++;
         if (pat_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_last: got vld=%b rdy=%b, want vld=0 rdy=1", pat_valid, req_ready);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      check_idle_outputs_zero("reset_values");
      // req_valid high in the release cycle must not be accepted.
      rst        = 1'b0;
      req_valid  = 1'b1;
      req_weight = 5'b00010;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || pat_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", req_ready, pat_valid);
      end
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (pat_valid !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL release_accept: got vld=%b err=%b, want 0 0", pat_valid, err);
      end
   endtask

   task automatic test_weight2();
      int n;
      request(5'b00100);
      drain(1'b0, 100, n);
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL weight2_count: got %0d, want 6", n);
      end
   endtask

   task automatic test_single();
      int n;
      request(5'b00001);
      drain(1'b0, 100, n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL weight0_count: got %0d, want 1", n);
      end
      request(5'b10000);
      drain(1'b0, 100, n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL weight4_count: got %0d, want 1", n);
      end
   endtask

   task automatic test_backpressure();
      int n;
      request(5'b00010);
      drain(1'b1, 100, n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL bp_count: got %0d, want 4", n);
      end
      pat_ready = 1'b1;
   endtask

   task automatic test_illegal();
      logic [WIDTH:0] bad [2];
      bad[0] = 5'b00110;
      bad[1] = 5'b00000;
      for (int i = 0; i < 2; i++) begin
         req_valid  = 1'b1;
         req_weight = bad[i];
         @(negedge clk);
         req_valid = 1'b0;
         checks++;
         if (err !== 1'b1 || req_ready !== 1'b0 || pat_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse %b: got err=%b rdy=%b vld=%b, want 1 0 0",
                     bad[i], err, req_ready, pat_valid);
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || req_ready !== 1'b1 || pat_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_recover %b: got err=%b rdy=%b vld=%b, want 0 1 0",
                     bad[i], err, req_ready, pat_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      request(5'b01000);
      drain(1'b0, 2, n);
      rst = 1'b1;
      #1;
      check_idle_outputs_zero("reset_mid");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      request(5'b00010);
      drain(1'b0, 100, n);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL post_reset_count: got %0d, want 4", n);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int total;
      total = 0;
      for (int k = 0; k <= WIDTH; k++) begin
         request((WIDTH+1)'(1) << k);
         drain(1'b0, 100, n);
         total += n;
      end
      checks++;
      if (total !== 16) begin
         errors++;
         $display("FAIL exhaustive_total: got %0d, want 16", total);
      end
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_weight = '0;
      pat_ready  = 1'b0;
      cur_weight = '0;
      test_reset();
      test_weight2();
      test_single();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
